// File: rtl/theta_result_receiver_pkg.sv
// Shared definitions for theta_result_receiver: channel state codes, default
// parameter values and the FIFO level-width helper.
package theta_result_receiver_pkg;

   localparam logic [1:0] CH_IDLE   = 2'd0;
   localparam logic [1:0] CH_SETTLE = 2'd1;
   localparam logic [1:0] CH_HOLD   = 2'd2;
   localparam logic [1:0] CH_ACK    = 2'd3;

   localparam int DEF_DEPTH   = 4;
   localparam int DEF_CAP_DLY = 1;
   localparam int DEF_TIMEOUT = 1024;

   // Occupancy must represent 0..depth inclusive.
   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/theta_result_receiver_cas_channel.sv
// cas_channel_rx: one four-phase strobe/acknowledge channel with a settle
// delay before the data bus is sampled into the channel register.
module cas_channel_rx
   import theta_result_receiver_pkg::*;
#(
   parameter int N       = 32,
   parameter int CAP_DLY = DEF_CAP_DLY
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         strobe,
   input  logic [N-1:0] data,
   input  logic         commit,
   input  logic         abort,
   output logic         hold,
   output logic         ack,
   output logic [N-1:0] cap_data
);

   localparam int CW = (CAP_DLY > 1) ? $clog2(CAP_DLY) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CAP_DLY - 1);

   logic [1:0]    state_r, state_nxt_s;
   logic [CW-1:0] cnt_r, cnt_nxt_s;
   logic [N-1:0]  data_r, data_nxt_s;
   logic          ack_r;

   // Next-state logic; a dropped strobe always wins over commit or abort.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      data_nxt_s  = data_r;
      case (state_r)
         CH_IDLE: begin
            if (strobe) begin
               state_nxt_s = CH_SETTLE;
               cnt_nxt_s   = '0;
            end else begin
               state_nxt_s = CH_IDLE;
            end
         end
         CH_SETTLE: begin
            if (!strobe) begin
               state_nxt_s = CH_IDLE;
            end else if (cnt_r == CNT_LAST) begin
               data_nxt_s  = data;
               state_nxt_s = CH_HOLD;
            end else begin
               cnt_nxt_s = cnt_r + CW'(1);
            end
         end
         CH_HOLD: begin
            if (!strobe) begin
               state_nxt_s = CH_IDLE;
               data_nxt_s  = '0;
            end else if (abort) begin
               state_nxt_s = CH_ACK;
               data_nxt_s  = '0;
            end else if (commit) begin
               state_nxt_s = CH_ACK;
            end else begin
               state_nxt_s = CH_HOLD;
            end
         end
         CH_ACK: begin
            if (!strobe) begin
               state_nxt_s = CH_IDLE;
            end else begin
               state_nxt_s = CH_ACK;
            end
         end
         default: begin
            state_nxt_s = CH_IDLE;
         end
      endcase
   end

   // State, counter, capture register and the registered acknowledge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= CH_IDLE;
         cnt_r   <= '0;
         data_r  <= '0;
         ack_r   <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         data_r  <= data_nxt_s;
         ack_r   <= (state_nxt_s == CH_ACK);
      end
   end

   assign hold     = (state_r == CH_HOLD);
   assign ack      = ack_r;
   assign cap_data = data_r;

endmodule

// File: rtl/theta_result_receiver.sv
// Pairs the Is/alpha results into a show-ahead FIFO and returns paired cascade
// acknowledges. Define CAS_TIMEOUT_EN to release a lone held channel after TIMEOUT.
module theta_result_receiver
   import theta_result_receiver_pkg::*;
#(
   parameter int N       = 32,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int CAP_DLY = DEF_CAP_DLY,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          ACK_THETA_IF,
   input  logic                          ACK_THETA_VF,
   input  logic [N-1:0]                  RESULT_IS,
   input  logic [N-1:0]                  RESULT_ALPHA,
   output logic                          ACK_CAS_I,
   output logic                          ACK_CAS_V,
   output logic                          OUT_VALID,
   input  logic                          OUT_READY,
   output logic [N-1:0]                  OUT_IS,
   output logic [N-1:0]                  OUT_ALPHA,
   output logic [level_width(DEPTH)-1:0] FIFO_LEVEL,
   output logic                          PAIR_ERR
);

   localparam int LW = level_width(DEPTH);
   localparam int AW = $clog2(DEPTH);

   logic         hold_i_s, hold_v_s, abort_i_s, abort_v_s;
   logic         commit_s, pop_s, room_s;
   logic [N-1:0] cap_is_s, cap_alpha_s;

   logic [2*N-1:0] mem_r [DEPTH];
   logic [AW-1:0]  wr_ptr_r, rd_ptr_r;
   logic [LW-1:0]  level_r;

   cas_channel_rx #(.N(N), .CAP_DLY(CAP_DLY)) u_ch_i (
      .clk(CLK), .rst_n(RST), .strobe(ACK_THETA_IF), .data(RESULT_IS),
      .commit(commit_s), .abort(abort_i_s),
      .hold(hold_i_s), .ack(ACK_CAS_I), .cap_data(cap_is_s)
   );

   cas_channel_rx #(.N(N), .CAP_DLY(CAP_DLY)) u_ch_v (
      .clk(CLK), .rst_n(RST), .strobe(ACK_THETA_VF), .data(RESULT_ALPHA),
      .commit(commit_s), .abort(abort_v_s),
      .hold(hold_v_s), .ack(ACK_CAS_V), .cap_data(cap_alpha_s)
   );

   // A pop in the same cycle frees the slot the commit needs.
   assign pop_s    = (level_r != '0) & OUT_READY;
   assign room_s   = (level_r < LW'(DEPTH)) | pop_s;
   assign commit_s = hold_i_s & hold_v_s & ACK_THETA_IF & ACK_THETA_VF & room_s;

   // FIFO storage, pointers and occupancy.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         level_r  <= '0;
      end else begin
         if (commit_s) begin
            mem_r[wr_ptr_r] <= {cap_is_s, cap_alpha_s};
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({commit_s, pop_s})
            2'b10:   level_r <= level_r + LW'(1);
            2'b01:   level_r <= level_r - LW'(1);
            default: level_r <= level_r;
         endcase
      end
   end

   assign OUT_VALID            = (level_r != '0);
   assign {OUT_IS, OUT_ALPHA}  = mem_r[rd_ptr_r];
   assign FIFO_LEVEL           = level_r;

`ifdef CAS_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] to_cnt_r;
   logic          pair_err_r;
   logic          lone_s, expire_s;

   assign lone_s    = hold_i_s ^ hold_v_s;
   assign expire_s  = lone_s & (to_cnt_r == TW'(TIMEOUT - 1));
   assign abort_i_s = expire_s & hold_i_s;
   assign abort_v_s = expire_s & hold_v_s;

   // Lone-hold timer and sticky pairing error.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         to_cnt_r   <= '0;
         pair_err_r <= 1'b0;
      end else begin
         if (!lone_s || expire_s) begin
            to_cnt_r <= '0;
         end else begin
            to_cnt_r <= to_cnt_r + TW'(1);
         end
         if (expire_s) begin
            pair_err_r <= 1'b1;
         end else begin
            pair_err_r <= pair_err_r;
         end
      end
   end

   assign PAIR_ERR = pair_err_r;
`else
   assign abort_i_s = 1'b0;
   assign abort_v_s = 1'b0;
   assign PAIR_ERR  = 1'b0;
`endif

endmodule
